// File: rtl/ucore_axi_pkg.sv
// ----------------------------------------------------------------------------
// ucore_axi_pkg
//   Shared AXI4 encodings and the read-arbiter state type used by the
//   ucore memory-side blocks.
// ----------------------------------------------------------------------------
package ucore_axi_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [2:0] SIZE_4B       = 3'b010;
    localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;  // bufferable, modifiable
    localparam logic [7:0] LEN_SINGLE    = 8'd0;
    localparam logic [2:0] PROT_INSN     = 3'b100;   // unprivileged, secure, instruction
    localparam logic [2:0] PROT_DATA     = 3'b000;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;    // bit 1 is also set for DECERR

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_e;

endpackage

// File: rtl/ucore_rr_pick.sv
// ----------------------------------------------------------------------------
// ucore_rr_pick
//   Combinational round-robin picker. Searches req starting at ptr and
//   wrapping modulo N; the first set bit wins.
// Ports
//   req  in   N    request vector
//   ptr  in   IW   highest-priority index this round
//   gnt  out  N    one-hot grant (zero when no request)
//   idx  out  IW   index of the granted requester
//   any  out  1    at least one request present
// ----------------------------------------------------------------------------
module ucore_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ucore_axi_rd_arb.sv
// ----------------------------------------------------------------------------
// ucore_axi_rd_arb
//   Shares the core's single AXI4 read master between NREQ requesters
//   (0 = instruction fetch, others = data loads). Round-robin, one
//   outstanding single-beat 32-bit read at a time.
// Ports
//   clk, aresetn             clock, async active-low reset
//   req_valid/req_addr       per-requester request, held until req_ready
//   req_ready                one-cycle one-hot acceptance pulse
//   rsp_valid/rsp_data/err   one-cycle one-hot response to the owner
//   m_axi_ar*                AXI4 AR channel (single beat, INCR, 4 bytes)
//   m_axi_r*, m_axi_rready   AXI4 R channel
// ----------------------------------------------------------------------------
module ucore_axi_rd_arb #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic [ADDR_W-1:0]        m_axi_araddr,
    output logic [1:0]               m_axi_arburst,
    output logic [3:0]               m_axi_arcache,
    output logic [ID_W-1:0]          m_axi_arid,
    output logic [7:0]               m_axi_arlen,
    output logic                     m_axi_arlock,
    output logic [2:0]               m_axi_arprot,
    output logic [3:0]               m_axi_arqos,
    output logic [2:0]               m_axi_arsize,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [DATA_W-1:0]        m_axi_rdata,
    input  logic [ID_W-1:0]          m_axi_rid,
    input  logic                     m_axi_rlast,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);
    import ucore_axi_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e    state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          ar_hs, r_hs;

    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid & m_axi_rready;

    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arcache = CACHE_BUF_MOD;
    assign m_axi_arlen   = LEN_SINGLE;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arsize  = SIZE_4B;

    ucore_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ADDR;
            ADDR:    if (ar_hs)    state_nxt = DATA;
            DATA:    if (r_hs)     state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr        <= '0;
            owner         <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arid    <= '0;
            m_axi_arprot  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: if (pick_any) begin
                    req_ready     <= pick_gnt;
                    owner         <= pick_idx;
                    // Word-align: only single 4-byte beats are issued.
                    m_axi_araddr  <= {req_addr[int'(pick_idx)*ADDR_W + 2 +: ADDR_W-2], 2'b00};
                    m_axi_arid    <= ID_W'(pick_idx);
                    m_axi_arprot  <= (pick_idx == '0) ? PROT_INSN : PROT_DATA;
                    m_axi_arvalid <= 1'b1;
                end
                ADDR: if (ar_hs) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                end
                DATA: if (r_hs) begin
                    m_axi_rready <= 1'b0;
                    rsp_valid    <= NREQ'(1) << owner;
                    rsp_data     <= m_axi_rdata;
                    // Slave error, a beat tagged for someone else, or a
                    // multi-beat reply to a single-beat request are all
                    // reported as an error to the owner.
                    rsp_err      <= (|(m_axi_rresp & RESP_SLVERR)) |
                                    (m_axi_rid != ID_W'(owner)) | ~m_axi_rlast;
                    rr_ptr       <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ucore_axi_rd_arb.sv
module tb_ucore_axi_rd_arb;
    localparam int NREQ = 2;
    localparam int AW   = 28;
    localparam int DW   = 32;
    localparam int IDW  = 4;

    logic                 clk = 1'b0;
    logic                 aresetn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 rsp_err;
    logic [AW-1:0]        araddr;
    logic [1:0]           arburst;
    logic [3:0]           arcache;
    logic [IDW-1:0]       arid;
    logic [7:0]           arlen;
    logic                 arlock;
    logic [2:0]           arprot;
    logic [3:0]           arqos;
    logic [2:0]           arsize;
    logic                 arvalid;
    logic                 arready = 1'b0;
    logic [DW-1:0]        rdata = '0;
    logic [IDW-1:0]       rid = '0;
    logic                 rlast = 1'b0;
    logic [1:0]           rresp = '0;
    logic                 rvalid = 1'b0;
    logic                 rready;

    always #5 clk = ~clk;

    ucore_axi_rd_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ID_W(IDW)) dut (
        .clk(clk), .aresetn(aresetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_axi_araddr(araddr), .m_axi_arburst(arburst), .m_axi_arcache(arcache),
        .m_axi_arid(arid), .m_axi_arlen(arlen), .m_axi_arlock(arlock),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arsize(arsize),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rid(rid), .m_axi_rlast(rlast),
        .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // One read is "outstanding" from acceptance until its R beat is taken.
    // Requests are looked at only while nothing is outstanding; the winner is
    // the first requester at or after the pointer, and the pointer moves past
    // the owner once its data has come back.
    bit              m_busy, m_ar_done, m_gnt_pend, m_rsp_pend, m_rsp_err;
    int              m_ptr, m_owner, m_gnt_idx, m_rsp_idx;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_rsp_data;

    task automatic model_reset();
        m_busy = 0; m_ar_done = 0; m_gnt_pend = 0; m_rsp_pend = 0; m_rsp_err = 0;
        m_ptr = 0; m_owner = 0; m_gnt_idx = 0; m_rsp_idx = 0;
        m_addr = '0; m_rsp_data = '0;
    endtask

    task automatic model_cycle();
        bit was_busy;
        logic [NREQ-1:0] exp_oh;
        if (!aresetn) begin
            chk("rst_ctl", {req_ready, rsp_valid, rsp_err, arvalid, arprot, rready}, 64'd0);
            chk("rst_data", rsp_data, 64'd0);
            chk("rst_ar", {araddr, arid}, 64'd0);
            model_reset();
            return;
        end
        exp_oh = '0;
        if (m_gnt_pend) exp_oh[m_gnt_idx] = 1'b1;
        chk("req_ready", req_ready, exp_oh);
        chk("arvalid", arvalid, m_busy && !m_ar_done);
        if (m_busy && !m_ar_done)
            chk("ar_fields", {araddr, arid, arprot},
                {m_addr, IDW'(m_owner), (m_owner == 0) ? 3'b100 : 3'b000});
        chk("rready", rready, m_busy && m_ar_done);
        exp_oh = '0;
        if (m_rsp_pend) exp_oh[m_rsp_idx] = 1'b1;
        chk("rsp_valid", rsp_valid, exp_oh);
        if (m_rsp_pend) chk("rsp_payload", {rsp_err, rsp_data}, {m_rsp_err, m_rsp_data});

        m_gnt_pend = 0;
        m_rsp_pend = 0;
        was_busy = m_busy;
        if (m_busy && !m_ar_done) begin
            if (arready) m_ar_done = 1;
        end else if (m_busy && rvalid) begin
            m_rsp_pend = 1;
            m_rsp_idx  = m_owner;
            m_rsp_data = rdata;
            m_rsp_err  = rresp[1] || (int'(rid) != m_owner) || !rlast;
            m_ptr      = (m_owner + 1) % NREQ;
            m_busy     = 0;
        end
        if (!was_busy && (req_valid != 0)) begin
            for (int k = 0; k < NREQ; k++) begin
                int j = (m_ptr + k) % NREQ;
                if (req_valid[j]) begin
                    m_owner = j;
                    break;
                end
            end
            m_gnt_pend = 1;
            m_gnt_idx  = m_owner;
            m_busy     = 1;
            m_ar_done  = 0;
            m_addr     = req_addr[m_owner*AW +: AW] & ~AW'(3);
        end
    endtask

    // ---------------- random slave / requester bookkeeping ----------------
    logic [IDW-1:0]  arq[$];
    logic [NREQ-1:0] gq[$];
    logic [NREQ-1:0] seen_rr = '0;
    logic [NREQ-1:0] pend = '0;
    bit              r_active = 0;
    int              rsp_cnt = 0;
    int              p_req = 0, p_ar = 0, p_r = 0, p_junk = 0, p_bad = 0;
    bit              hold_all = 0;

    task automatic monitor();
        seen_rr = req_ready;
        if (req_ready != 0) gq.push_back(req_ready);
        if (rsp_valid != 0) rsp_cnt++;
        if (arvalid && arready) arq.push_back(arid);
        if (rvalid && rready) begin
            if (arq.size() > 0) arq.delete(0);
            r_active = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            model_cycle();
            monitor();
        end
    end

    task automatic drive_rand();
        for (int i = 0; i < NREQ; i++) begin
            if (seen_rr[i]) begin
                pend[i] = 1'b0;
                req_valid[i] = 1'b0;
            end
            if (!pend[i] && (hold_all || ($urandom % 100) < p_req)) begin
                pend[i] = 1'b1;
                req_valid[i] = 1'b1;
                req_addr[i*AW +: AW] = AW'($urandom());
            end
        end
        arready = ($urandom % 100) < p_ar;
        if (!r_active) begin
            if (arq.size() > 0 && ($urandom % 100) < p_r) begin
                r_active = 1;
                rvalid = 1'b1;
                rdata  = $urandom();
                rid    = arq[0];
                if (($urandom % 100) < p_bad) rid = rid ^ IDW'($urandom_range(1, 15));
                rlast  = !(($urandom % 100) < p_bad);
                rresp  = (($urandom % 100) < p_bad) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
            end else if (arq.size() == 0 && ($urandom % 100) < p_junk) begin
                rvalid = 1'b1;
                rdata  = $urandom();
                rid    = IDW'($urandom());
                rlast  = 1'b1;
                rresp  = 2'b00;
            end else begin
                rvalid = 1'b0;
            end
        end
    endtask

    // ---------------- directed single transaction ----------------
    task automatic do_txn(input int win, input logic [AW-1:0] addr, input int ar_wait,
                          input bit stray, input logic [DW-1:0] data, input logic [IDW-1:0] rid_v,
                          input bit last_v, input logic [1:0] resp_v,
                          input logic [AW-1:0] exp_addr, input bit exp_err);
        logic [NREQ-1:0] oh;
        logic [2:0]      eprot;
        oh = '0;
        oh[win] = 1'b1;
        eprot = (win == 0) ? 3'b100 : 3'b000;
        tick();
        req_addr[win*AW +: AW] = addr;
        req_valid = oh;
        arready = 1'b0;
        rvalid = 1'b0;
        tick();
        @(negedge clk);
        chk("t_req_ready", req_ready, oh);
        chk("t_ar", {arvalid, araddr, arid, arprot}, {1'b1, exp_addr, IDW'(win), eprot});
        chk("t_ar_const", {arlen, arsize, arburst, arcache, arlock, arqos},
            {8'd0, 3'b010, 2'b01, 4'b0011, 1'b0, 4'd0});
        for (int k = 1; k <= ar_wait; k++) begin
            tick();
            req_valid = '0;
            arready = (k == ar_wait);
            if (stray) begin
                rvalid = 1'b1; rdata = data; rid = rid_v; rlast = last_v; rresp = resp_v;
            end
            @(negedge clk);
            chk("t_ar_hold", {arvalid, araddr, arid, arprot}, {1'b1, exp_addr, IDW'(win), eprot});
            chk("t_no_r_in_addr", {rready, rsp_valid}, 64'd0);
        end
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = data; rid = rid_v; rlast = last_v; rresp = resp_v;
        @(negedge clk);
        chk("t_rready", {rready, arvalid}, 64'd2);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        chk("t_rsp", rsp_valid, oh);
        chk("t_rsp_data", rsp_data, data);
        chk("t_rsp_err", rsp_err, exp_err);
        tick();
        @(negedge clk);
        chk("t_rsp_pulse", rsp_valid, 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outs", {req_ready, rsp_valid, arvalid, rready, arprot, arid}, 64'd0);
        tick();
        aresetn = 1'b1;

        // fetch read, arready after 2 cycles
        do_txn(0, 28'h0000100, 2, 0, 32'hDEADBEEF, 4'd0, 1, 2'b00, 28'h0000100, 0);
        // unaligned data read, long arready stall
        do_txn(1, 28'h0000103, 6, 0, 32'h12345678, 4'd1, 1, 2'b00, 28'h0000100, 0);
        // error sources
        do_txn(0, 28'hABCDEF4, 1, 0, 32'hCAFEF00D, 4'd0, 1, 2'b10, 28'hABCDEF4, 1);
        do_txn(1, 28'h0000208, 1, 0, 32'h00000001, 4'd3, 1, 2'b00, 28'h0000208, 1);
        do_txn(0, 28'h0000045, 1, 0, 32'h00000002, 4'd0, 0, 2'b00, 28'h0000044, 1);
        // R beat presented before the address handshake; leaves pointer at 1
        do_txn(0, 28'hFFFFFFF, 3, 1, 32'h5A5A5A5A, 4'd0, 1, 2'b01, 28'hFFFFFFC, 0);

        // reset while a beat is pending in the data phase
        tick();
        req_addr[0 +: AW] = 28'h0000300;
        req_valid = 2'b01;
        arready = 1'b1;
        tick();
        req_valid = '0;
        arready = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h11112222; rid = 4'd0; rlast = 1'b1; rresp = 2'b00;
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst_ctl", {req_ready, rsp_valid, rsp_err, arvalid, rready, arprot, arid}, 64'd0);
        chk("async_rst_dat", {rsp_data, araddr}, 64'd0);
        tick();
        tick();
        aresetn = 1'b1;
        rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("post_rst_quiet", {rsp_valid, rready}, 64'd0);
        end

        // two requesters held continuously, zero-wait slave
        arq.delete();
        gq.delete();
        r_active = 0;
        pend = '0;
        hold_all = 1; p_ar = 100; p_r = 100; p_junk = 0; p_bad = 0;
        repeat (13) begin
            tick();
            drive_rand();
        end
        chk("t2_grant_cnt", gq.size() >= 4, 64'd1);
        if (gq.size() >= 4)
            for (int k = 0; k < 4; k++)
                chk("t2_grant_order", gq[k], (k % 2 == 0) ? 64'd1 : 64'd2);

        // randomized traffic
        hold_all = 0; p_req = 40; p_ar = 60; p_r = 50; p_junk = 10; p_bad = 15;
        rsp_cnt = 0;
        repeat (3000) begin
            tick();
            drive_rand();
        end
        chk("rand_progress", rsp_cnt > 100, 64'd1);

        tick();
        req_valid = '0;
        rvalid = 1'b0;
        arready = 1'b0;
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
